// File: rtl/innerproduct_pkg.sv
// Shared state encoding, sizing and saturating-add helpers for the
// innerproduct_mac datapath.
package innerproduct_pkg;

   typedef logic [1:0] state_t;

   localparam state_t IDLE  = 2'd0;
   localparam state_t ACCUM = 2'd1;
   localparam state_t DONE  = 2'd2;

   // Working width for the saturating add; wide enough for ACC_W up to 62.
   localparam int unsigned SAT_W = 64;

   typedef struct packed {
      logic signed [SAT_W-1:0] sum;
      logic                    clamp;
   } sat_t;

   function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
      return (a + b - 1) / b;
   endfunction

   // Adds a and b, clamping to the signed range of a w-bit result.
   function automatic sat_t sat_add(input logic signed [SAT_W-1:0] a,
                                    input logic signed [SAT_W-1:0] b,
                                    input int unsigned             w);
      sat_t                    r;
      logic signed [SAT_W-1:0] s;
      logic signed [SAT_W-1:0] hi;
      logic signed [SAT_W-1:0] lo;
      s       = a + b;
      hi      = (64'sd1 <<< (w - 1)) - 64'sd1;
      lo      = -hi - 64'sd1;
      r.sum   = s;
      r.clamp = 1'b0;
      if (s > hi) begin
         r.sum   = hi;
         r.clamp = 1'b1;
      end else if (s < lo) begin
         r.sum   = lo;
         r.clamp = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/innerproduct_mac_tree.sv
// mac_lane_tree: LANES unsigned-pixel x signed-coefficient multipliers feeding
// a balanced adder tree; disabled lanes contribute zero.
module mac_lane_tree
   import innerproduct_pkg::*;
#(
   parameter int unsigned X_W     = 7,
   parameter int unsigned THETA_W = 16,
   parameter int unsigned LANES   = 9,
   parameter int unsigned SUM_W   = X_W + THETA_W + 1 + $clog2(LANES)
) (
   input  logic [LANES*X_W-1:0]     x,
   input  logic [LANES*THETA_W-1:0] theta,
   input  logic [LANES-1:0]         en,
   output logic signed [SUM_W-1:0]  sum
);

   localparam int unsigned P_W  = X_W + THETA_W + 1;
   localparam int unsigned LVLS = $clog2(LANES);

   logic signed [P_W-1:0]   prod [LANES];
   logic signed [SUM_W-1:0] node [LANES];

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic signed [X_W:0]       xe;
      logic signed [THETA_W-1:0] th;
      assign xe      = {1'b0, x[l*X_W +: X_W]};
      assign th      = theta[l*THETA_W +: THETA_W];
      assign prod[l] = en[l] ? (P_W'(xe) * P_W'(th)) : '0;
   end

   // In-place pairwise reduction: at level k, lane j (j multiple of 2^(k+1))
   // absorbs lane j+2^k, so node[0] ends up holding the full sum.
   always_comb begin
      for (int unsigned j = 0; j < LANES; j++) begin
         node[j] = SUM_W'(prod[j]);
      end
      for (int unsigned k = 0; k < LVLS; k++) begin
         for (int unsigned j = 0; j < LANES; j++) begin
            if ((j % (2 << k)) == 0 && (j + (1 << k)) < LANES) begin
               node[j] = node[j] + node[j + (1 << k)];
            end
         end
      end
      sum = node[0];
   end

endmodule

// File: rtl/innerproduct_mac.sv
// innerproduct_mac: time-multiplexed saturating inner product of one N_TAPS
// pixel window against a runtime-loadable signed coefficient file.
module innerproduct_mac
   import innerproduct_pkg::*;
#(
   parameter int unsigned N_TAPS  = 81,
   parameter int unsigned X_W     = 7,
   parameter int unsigned THETA_W = 16,
   parameter int unsigned LANES   = 9,
   parameter int unsigned ACC_W   = 32
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        theta_we,
   input  logic [$clog2(N_TAPS)-1:0]   theta_addr,
   input  logic [THETA_W-1:0]          theta_wdata,
   output logic                        theta_ready,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  logic [N_TAPS*X_W-1:0]       x_flat,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic signed [ACC_W-1:0]     hprime,
   output logic                        ovf
);

   localparam int unsigned AW    = $clog2(N_TAPS);
   localparam int unsigned BEATS = ceil_div(N_TAPS, LANES);
   localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int unsigned N_PAD = BEATS * LANES;
   localparam int unsigned P_W   = X_W + THETA_W + 1;
   localparam int unsigned SUM_W = P_W + $clog2(LANES);

   localparam logic [AW:0]   NTAPS_V   = (AW + 1)'(N_TAPS);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   state_t                    state;
   logic [BW-1:0]             beat;
   logic [N_TAPS*X_W-1:0]     x_reg;
   logic signed [THETA_W-1:0] theta_q [N_TAPS];
   logic signed [ACC_W-1:0]   acc;
   logic                      ovf_q;

   logic [N_PAD*X_W-1:0]      x_pad;
   logic [N_PAD*THETA_W-1:0]  th_pad;
   logic [LANES*X_W-1:0]      lane_x;
   logic [LANES*THETA_W-1:0]  lane_th;
   logic [LANES-1:0]          lane_en;
   logic signed [SUM_W-1:0]   lane_sum;
   sat_t                      sat;
   logic                      sat_hi_unused;
   logic                      theta_hit;

   assign in_ready    = (state == IDLE);
   assign theta_ready = (state == IDLE);
   assign out_valid   = (state == DONE);
   assign hprime      = acc;
   assign ovf         = ovf_q;

   assign theta_hit = theta_we && theta_ready && ({1'b0, theta_addr} < NTAPS_V);

   // Taps are zero-padded to a whole number of beats; lanes past N_TAPS are
   // additionally masked off so the tree never sees padding as data.
   always_comb begin
      x_pad                    = '0;
      x_pad[N_TAPS*X_W-1:0]    = x_reg;
      th_pad                   = '0;
      for (int unsigned i = 0; i < N_TAPS; i++) begin
         th_pad[i*THETA_W +: THETA_W] = theta_q[i];
      end
      lane_x  = x_pad[32'(beat) * LANES * X_W +: LANES * X_W];
      lane_th = th_pad[32'(beat) * LANES * THETA_W +: LANES * THETA_W];
      for (int unsigned l = 0; l < LANES; l++) begin
         lane_en[l] = ((32'(beat) * LANES + l) < N_TAPS);
      end
   end

   mac_lane_tree #(
      .X_W     (X_W),
      .THETA_W (THETA_W),
      .LANES   (LANES),
      .SUM_W   (SUM_W)
   ) u_tree (
      .x     (lane_x),
      .theta (lane_th),
      .en    (lane_en),
      .sum   (lane_sum)
   );

   always_comb begin
      sat = sat_add(SAT_W'(acc), SAT_W'(lane_sum), ACC_W);
   end

   assign sat_hi_unused = ^sat.sum[SAT_W-1:ACC_W];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         beat  <= '0;
         x_reg <= '0;
         acc   <= '0;
         ovf_q <= 1'b0;
         for (int unsigned i = 0; i < N_TAPS; i++) begin
            theta_q[i] <= '0;
         end
      end else begin
         if (theta_hit) begin
            theta_q[theta_addr] <= theta_wdata;
         end
         case (state)
            IDLE: begin
               if (in_valid) begin
                  x_reg <= x_flat;
                  acc   <= '0;
                  ovf_q <= 1'b0;
                  beat  <= '0;
                  state <= ACCUM;
               end
            end
            ACCUM: begin
               acc   <= sat.sum[ACC_W-1:0];
               ovf_q <= ovf_q | sat.clamp;
               if (beat == LAST_BEAT) begin
                  state <= DONE;
               end else begin
                  beat <= beat + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/innerproduct_mac.md
# innerproduct_mac

Time-multiplexed, parametrised inner-product engine for the line-buffer logistic-regression datapath. It takes one N_TAPS-pixel window and computes hprime = Σ x[i]·theta[i] over ceil(N_TAPS/LANES) clock cycles, using LANES multipliers. Theta is held in runtime-loadable signed registers, so the coefficient set is no longer fixed at synthesis. The block sits between the window line buffer and the sigmoid/threshold stage, with valid/ready handshakes on both sides.

## Interface
- N_TAPS, 81: window size (9×9).
- X_W, 7: pixel width, unsigned.
- THETA_W, 16: coefficient width, signed two's complement.
- LANES, 9: taps multiplied per cycle, 1..N_TAPS.
- ACC_W, 32: accumulator/result width, signed.
- clk  in  1  clock; single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- theta_we  in  1  coefficient write strobe.
- theta_addr  in  clog2(N_TAPS)  coefficient index.
- theta_wdata  in  THETA_W  coefficient value.
- theta_ready  out  1  coefficient writes accepted (high only in IDLE).
- in_valid  in  1  window valid.
- in_ready  out  1  window accepted when in_valid && in_ready.
- x_flat  in  N_TAPS*X_W  window, tap i at bits [i*X_W +: X_W].
- out_valid  out  1  result valid; held until taken.
- out_ready  in  1  downstream accepts the result.
- hprime  out  ACC_W  signed inner product, saturated.
- ovf  out  1  saturation occurred during this result.

## Operation
- FSM states: IDLE, ACCUM, DONE.
  - IDLE: in_ready=1, theta_ready=1. On an in_valid handshake: register x_flat, clear acc/ovf/beat counter, go to ACCUM.
  - ACCUM: each cycle add one lane-sum of taps [beat*LANES, beat*LANES+LANES-1] to acc, then increment beat. After the beat BEATS-1 update, go to DONE. BEATS = ceil(N_TAPS/LANES).
  - DONE: out_valid=1, and hprime/ovf are stable. On out_valid && out_ready, go to IDLE.
- Theta writes:
  - A write takes effect at the clock edge where theta_we && theta_ready.
  - theta_we is ignored when theta_ready=0; there is no queuing.
  - A theta_addr ≥ N_TAPS is ignored.
- Arithmetic:
  - x is zero-extended to X_W+1 bits and treated as signed; the product is X_W+THETA_W+1 bits signed.
  - The lane sum is full-precision (product width + clog2(LANES)).
  - acc+lane_sum saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1], and ovf is set sticky on any clamp.
- Partial last beat: lanes with tap index ≥ N_TAPS contribute 0.
- Priority: rst_n low overrides everything. Reset mid-ACCUM discards the partial sum.

## Timing
- Reset values:
  - state=IDLE, in_ready=1, theta_ready=1.
  - out_valid=0, hprime=0, ovf=0.
  - All theta registers = 0.
- Latency: the window handshake at edge k is followed by out_valid=1 after edge k+BEATS (9 cycles for the defaults).
- in_ready falls the cycle after acceptance.
- in_ready returns the cycle after the output handshake.
- Throughput: one window per BEATS+2 cycles minimum, with out_ready tied high.
- out_valid never drops without a handshake, and hprime does not change while out_valid=1.
- A theta write in the same cycle as a window handshake is applied. That window uses the new value.

## Structure
- Package innerproduct_pkg:
  - state enum {IDLE, ACCUM, DONE};
  - ceil_div function;
  - saturation helper (sat_add of ACC_W).
- Sub-module mac_lane_tree: combinational, LANES signed multipliers + adder tree, with a per-lane enable mask for the partial last beat.
- Top level holds the FSM, beat counter, x register, theta register file and saturating accumulator.

## Test plan
- Single window, all x=1, theta[i]=i (i=0..80), out_ready=1:
  - hprime=3240, ovf=0;
  - out_valid rises 9 cycles after acceptance.
- Signed weights: x all 127, theta all -1 → hprime=-10287.
- Saturation: ACC_W=20, x all 127, theta all 32767 → hprime=524287, ovf=1. Next window with theta all 0 → hprime=0, ovf=0.
- Partial beat: N_TAPS=10, LANES=4, x all 2, theta all 3 → BEATS=3, hprime=60.
- Backpressure and gating:
  - Hold out_ready=0 for 20 cycles: out_valid and hprime stay stable, and in_ready=0 throughout.
  - A theta_we issued during ACCUM is ignored. Confirm the old value is used on the next window.
- Reset mid-ACCUM (beat 4): out_valid stays 0, in_ready=1 next cycle, theta reads as 0, and the next window gives hprime=0.
